// File: rtl/mux4x1_stim_checker.sv
// mux4x1_stim_checker: sweeps all 64 data/select vectors into a 4:1 mux,
// samples its output after a settle time and counts mismatches.
module mux4x1_stim_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] t1,
    output logic [1:0] t2,
    input  logic       p,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       mismatch,
    output logic [6:0] err_cnt,
    output logic [5:0] vec_idx
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] vec_q, vec_d;
    logic [6:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic       mis_q, mis_d;
    logic       exp_v;

    // t1/t2 are the vector register itself, so they change on the same edge as vec_idx
    assign t1       = vec_q[3:0];
    assign t2       = vec_q[5:4];
    assign exp_v    = t1[t2];
    assign busy     = (state_q == SETTLE) || (state_q == CHECK);
    assign done     = state_q == DONE;
    assign pass     = pass_q;
    assign mismatch = mis_q;
    assign err_cnt  = err_q;
    assign vec_idx  = vec_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        err_d   = err_q;
        pass_d  = pass_q;
        mis_d   = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = SETTLE;
                cnt_d   = RELOAD;
                vec_d   = '0;
                err_d   = '0;
                pass_d  = 1'b0;
            end
            SETTLE: if (cnt_q == '0) state_d = CHECK; else cnt_d = cnt_q - 4'd1;
            CHECK: begin
                mis_d = p != exp_v;
                err_d = err_q + 7'(mis_d);
                if (vec_q == 6'd63) begin
                    state_d = DONE;
                    pass_d  = err_d == '0;
                end else begin
                    state_d = SETTLE;
                    cnt_d   = RELOAD;
                    vec_d   = vec_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            mis_q   <= mis_d;
        end
    end
endmodule

// File: tb/tb_mux4x1_stim_checker.sv
// tb_mux4x1_stim_checker: drives two checkers (settle 2 and 1) against emulated
// good and faulty muxes and checks the verdicts against expected counts.
module tb_mux4x1_stim_checker;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    int mode = 0;
    logic [63:0] mask = '0;
    int cyc = 0, checks = 0, errors = 0;

    logic [3:0] t1_a, t1_b;
    logic [1:0] t2_a, t2_b;
    logic p_a, p_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b, mis_a, mis_b;
    logic [6:0] err_a, err_b;
    logic [5:0] vec_a, vec_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Emulated mux under test: 0 good, 1 stuck-0, 2 inverted, 3 sel swapped, 4 random fault mask
    function automatic logic mux_emu(int m, logic [3:0] d, logic [1:0] s, logic [63:0] mk);
        logic good;
        good = d[s];
        case (m)
            1: return 1'b0;
            2: return ~good;
            3: return d[{s[0], s[1]}];
            4: return good ^ mk[{s, d}];
            default: return good;
        endcase
    endfunction

    assign p_a = mux_emu(mode, t1_a, t2_a, mask);
    assign p_b = mux_emu(mode, t1_b, t2_b, mask);

    mux4x1_stim_checker #(.SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .t1(t1_a), .t2(t2_a), .p(p_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch(mis_a),
        .err_cnt(err_a), .vec_idx(vec_a));

    mux4x1_stim_checker #(.SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .t1(t1_b), .t2(t2_b), .p(p_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch(mis_b),
        .err_cnt(err_b), .vec_idx(vec_b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_a"}, {t1_a, t2_a, busy_a, done_a, pass_a, mis_a, err_a, vec_a}, 0);
        chk({name, "_b"}, {t1_b, t2_b, busy_b, done_b, pass_b, mis_b, err_b, vec_b}, 0);
    endtask

    task automatic run_sweep(input int m, input logic [63:0] mk, input int exp_err, input int exp_first);
        int ts, la, lb, ma, mb, fa, fb;
        bit sa, sb;
        mode = m;
        mask = mk;
        la = -1; lb = -1; ma = 0; mb = 0; fa = -1; fb = -1; sa = 0; sb = 0;
        @(negedge clk) start = 1'b1;
        ts = cyc + 1;
        @(negedge clk) start = 1'b0;
        chk("restart_cleared_a", {done_a, pass_a, err_a, vec_a, busy_a}, 1);
        for (int i = 0; i < 300 && !(sa && sb); i++) begin
            if (!sa) begin
                chk("vector_a", {t2_a, t1_a}, vec_a);
                if (mis_a) begin ma++; if (fa < 0) fa = done_a ? 63 : int'(vec_a) - 1; end
                if (done_a) begin sa = 1; la = cyc - ts; end
            end
            if (!sb) begin
                chk("vector_b", {t2_b, t1_b}, vec_b);
                if (mis_b) begin mb++; if (fb < 0) fb = done_b ? 63 : int'(vec_b) - 1; end
                if (done_b) begin sb = 1; lb = cyc - ts; end
            end
            @(negedge clk);
        end
        chk("latency_a", la, 192);
        chk("latency_b", lb, 128);
        chk("err_cnt_a", err_a, exp_err);
        chk("err_cnt_b", err_b, exp_err);
        chk("pass_a", pass_a, exp_err == 0);
        chk("pass_b", pass_b, exp_err == 0);
        chk("mismatch_pulses_a", ma, exp_err);
        chk("mismatch_pulses_b", mb, exp_err);
        chk("first_fail_a", fa, exp_first);
        chk("first_fail_b", fb, exp_first);
        chk("done_held_a", {done_a, busy_a}, 2'b10);
    endtask

    typedef struct {
        int mode;
        int err;
        int first;
    } row_t;

    initial begin
        row_t tbl[4];
        logic [63:0] mk;
        int first;
        tbl[0] = '{0, 0, -1};
        tbl[1] = '{1, 32, 1};
        tbl[2] = '{2, 64, 0};
        tbl[3] = '{3, 16, 18};

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", {busy_a, done_a, busy_b, done_b}, 0);

        for (int r = 0; r < 4; r++) run_sweep(tbl[r].mode, '0, tbl[r].err, tbl[r].first);

        for (int r = 0; r < 3; r++) begin
            mk = {$urandom, $urandom} & {$urandom, $urandom};
            first = -1;
            for (int v = 63; v >= 0; v--) if (mk[v]) first = v;
            run_sweep(4, mk, $countones(mk), first);
        end

        // Restart after a failing sweep must report only the new sweep
        run_sweep(1, '0, 32, 1);
        run_sweep(0, '0, 0, -1);

        // Start ignored mid-sweep, then reset aborts at vector 30
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 100 && vec_a != 6'd5; i++) @(negedge clk);
        chk("reach_vec5", vec_a, 5);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("start_ignored", {busy_a, vec_a >= 6'd5, err_a}, {1'b1, 1'b1, 7'd0});
        for (int i = 0; i < 200 && vec_a != 6'd30; i++) @(negedge clk);
        chk("reach_vec30", vec_a, 30);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        @(negedge clk) rst_n = 1'b1;
        run_sweep(0, '0, 0, -1);

        // start held high: done lasts exactly one cycle before the next sweep
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 300 && !done_a; i++) @(negedge clk);
        chk("held_start_done", done_a, 1);
        @(negedge clk);
        chk("held_start_restart", {done_a, busy_a, vec_a}, {1'b0, 1'b1, 6'd0});
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux4x1_stim_checker.md
# mux4x1_stim_checker

Self-running stimulus generator and response checker for the 4:1 multiplexer bench. It sits directly upstream and downstream of the mux under test. It drives every data/select combination onto the mux inputs, samples the mux output after a programmable settle time, and compares it with the expected value. Mismatches are counted and a pass/fail verdict is produced. It is the clocked replacement for the free-running combinational tester.

## Interface
Parameters:
- SETTLE_CYCLES, 2, clocks between applying a vector and sampling `p`; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- t1  output  4  mux data inputs, connects to mux `in`.
- t2  output  2  mux select, connects to mux `sel`.
- p  input  1  mux output under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high in DONE, held until next start or reset.
- pass  output  1  valid when done: 1 if err_cnt==0.
- mismatch  output  1  one-cycle pulse on a failing compare.
- err_cnt  output  7  number of failing vectors in current or last sweep (0..64).
- vec_idx  output  6  index of vector currently driven.

## Operation
- Vector encoding: vec_idx[3:0] → t1, vec_idx[5:4] → t2. t1/t2 are registered copies of vec_idx at all times.
- Expected value: exp = t1[t2], computed from the registered t1/t2.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: on start=1, clear vec_idx, err_cnt, pass, settle counter; go to SETTLE.
- SETTLE: count SETTLE_CYCLES-1 down to 0. At 0, go to CHECK.
- CHECK: sample p and compare with exp.
  - On mismatch: err_cnt+1 and pulse mismatch.
  - If vec_idx==63: go to DONE and set pass = (final err_cnt==0), including this compare.
  - Otherwise: vec_idx+1, reload the settle counter, go to SETTLE.
- DONE: done=1. On start=1, behave as IDLE start: clear everything and go to SETTLE, with done dropping the same edge.
- start is ignored in SETTLE and CHECK. A sweep cannot be aborted except by reset.
- err_cnt is 7 bits and cannot overflow (maximum 64). vec_idx wraps naturally from 63 only via the explicit DONE transition, never by counting.
- A parameter outside 1..15 is a configuration error. The implementation flags it with an elaboration-time check.

## Timing
- Reset (async assert, sync release by the existing reset tree): state=IDLE; t1=0, t2=0, vec_idx=0, err_cnt=0; busy=0, done=0, pass=0, mismatch=0.
- busy=1 exactly in SETTLE and CHECK.
- Start accepted at edge E: vector 0 is on t1/t2 from E.
- Each vector occupies SETTLE_CYCLES cycles in SETTLE plus 1 cycle in CHECK, i.e. SETTLE_CYCLES+1 cycles.
- p is sampled at the edge ending the CHECK cycle. The vector has been stable for SETTLE_CYCLES+1 cycles by then.
- mismatch and the err_cnt increment are visible the cycle after that edge, coincident with the next vector appearing on t1/t2.
- Full sweep: done=1 at E + 64·(SETTLE_CYCLES+1). This is 192 cycles for the default.
- Reset asserted mid-sweep: all outputs return to reset values immediately (asynchronously). No partial verdict is retained.
- start held high continuously: a new sweep begins on the first cycle in DONE. done is visible for exactly one cycle.

## Test plan
- Correct behavioural mux, default parameter, single start pulse → done rises 192 cycles later; pass=1, err_cnt=0, mismatch never pulses.
- p tied to 0 → err_cnt=32, pass=0, with exactly 32 mismatch pulses.
- p inverted mux output → err_cnt=64, pass=0.
- Mux with sel bits swapped (sel 01↔10) → err_cnt=16; the first mismatch occurs at vec_idx=18 (t1=0010, t2=01).
- start pulses during SETTLE/CHECK, then reset asserted at vector 30 → start has no effect; after reset all outputs are 0. A new start completes a clean full sweep with pass=1.
- SETTLE_CYCLES=1; a second start issued in DONE after a failing sweep → done after 128 cycles; err_cnt is cleared on restart, and the final verdict reflects only the second sweep.
